// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake between the pipeline controller and the multiply/divide unit.
// The controller drives operands and MTHI/MTLO writes; the unit returns status and HI/LO.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Works on unsigned magnitudes for 32 cycles, then applies signs in a single fix-up cycle.
module mult_div_unit (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [1:0]  op_r;
    logic [31:0] opnd_r;      // multiplicand (mult) or divisor (div) magnitude
    logic [63:0] acc_r;       // mult: {partial product, multiplier}; div: [31:0] dividend -> quotient
    logic [31:0] rem_r;
    logic [4:0]  cnt_r;
    logic        sign_q_r;
    logic        sign_r_r;
    logic        b_zero_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        start_signed_s;
    logic [31:0] start_mag_a_s;
    logic [31:0] start_mag_b_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic [31:0] div_sub_s;
    logic        div_ge_s;
    logic [63:0] fix_prod_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return ~v + 32'd1;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: 32 iterations in CALC, one fix-up cycle, back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == 5'd31) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_FIX:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand magnitudes, one iteration step of each datapath, and sign-fixed results.
    always_comb begin
        start_signed_s = ~bus.op[0];
        start_mag_a_s  = mag32(bus.a, start_signed_s);
        start_mag_b_s  = mag32(bus.b, start_signed_s);

        mul_sum_s = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);

        // Bit 32 of the shifted remainder takes part only in the compare; a successful
        // subtract always leaves a remainder below the divisor, so 32 bits hold it.
        div_shift_s = {rem_r, acc_r[31]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        div_sub_s   = div_shift_s[31:0] - opnd_r;

        fix_prod_s = sign_q_r ? neg64(acc_r) : acc_r;
        // Divide by zero yields an all-ones quotient regardless of operand signs.
        fix_lo_s   = (sign_q_r && !b_zero_r) ? neg32(acc_r[31:0]) : acc_r[31:0];
        fix_hi_s   = sign_r_r ? neg32(rem_r) : rem_r;
    end

    // Datapath, HI/LO registers and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= 2'b00;
            opnd_r   <= 32'd0;
            acc_r    <= 64'd0;
            rem_r    <= 32'd0;
            cnt_r    <= 5'd0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            b_zero_r <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.hi_we) begin
                        hi_r <= bus.wdata;
                    end
                    if (bus.lo_we) begin
                        lo_r <= bus.wdata;
                    end
                    if (bus.start) begin
                        op_r     <= bus.op;
                        rem_r    <= 32'd0;
                        cnt_r    <= 5'd0;
                        sign_q_r <= start_signed_s & (bus.a[31] ^ bus.b[31]);
                        sign_r_r <= start_signed_s & bus.a[31];
                        b_zero_r <= (bus.b == 32'd0);
                        busy_r   <= 1'b1;
                        if (bus.op[1]) begin
                            opnd_r <= start_mag_b_s;
                            acc_r  <= {32'd0, start_mag_a_s};
                        end else begin
                            opnd_r <= start_mag_a_s;
                            acc_r  <= {32'd0, start_mag_b_s};
                        end
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (op_r[1]) begin
                        if (div_ge_s) begin
                            rem_r        <= div_sub_s;
                            acc_r[31:0] <= {acc_r[30:0], 1'b1};
                        end else begin
                            rem_r        <= div_shift_s[31:0];
                            acc_r[31:0] <= {acc_r[30:0], 1'b0};
                        end
                    end else begin
                        acc_r <= {mul_sum_s, acc_r[31:1]};
                    end
                end
                ST_FIX: begin
                    if (op_r[1]) begin
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
                    end else begin
                        hi_r <= fix_prod_s[63:32];
                        lo_r <= fix_prod_s[31:0];
                    end
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule
